// File: rtl/dice_game_ctrl.sv
// Purpose: craps-style controller; gates the dice counter while roll is held, scores the sum on release.
// Latency: press/release act on the next rising edge; outcomes and err are visible one cycle after the release edge.
// Backpressure: none; win/lose hold until new_game, and roll is ignored once the game is over.
module dice_game_ctrl #(
    parameter int ROLLS_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               roll,
    input  logic               new_game,
    input  logic [3:0]         sum,
    output logic               dice_en,
    output logic [3:0]         point,
    output logic               win,
    output logic               lose,
    output logic               err,
    output logic [ROLLS_W-1:0] rolls
);

    typedef enum logic [2:0] {
        FIRST = 3'd0,
        ROLL1 = 3'd1,
        POINT = 3'd2,
        ROLLP = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    state_t state;
    logic   roll_q;
    logic   press;
    logic   sum_legal;
    logic   rolls_max;

    assign press     = roll & ~roll_q;
    assign sum_legal = (sum >= 4'd2) && (sum <= 4'd12);
    assign rolls_max = &rolls;

    // Moore outputs decoded straight from the state register.
    assign dice_en = (state == ROLL1) || (state == ROLLP);
    assign win     = (state == WIN);
    assign lose    = (state == LOSE);

    // Game state machine plus the point, roll count and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FIRST;
            roll_q <= 1'b0;
            point  <= 4'd0;
            rolls  <= '0;
            err    <= 1'b0;
        end else begin
            roll_q <= roll;
            err    <= 1'b0;
            if (new_game) begin
                // Restart wins over any press or release seen on the same edge.
                state <= FIRST;
                point <= 4'd0;
                rolls <= '0;
            end else begin
                case (state)
                    FIRST: if (press) state <= ROLL1;
                    POINT: if (press) state <= ROLLP;
                    ROLL1: begin
                        if (!roll) begin
                            if (!sum_legal) begin
                                err   <= 1'b1;
                                state <= FIRST;
                            end else begin
                                if (!rolls_max) rolls <= rolls + 1'b1;
                                case (sum)
                                    4'd7, 4'd11:        state <= WIN;
                                    4'd2, 4'd3, 4'd12:  state <= LOSE;
                                    default: begin
                                        point <= sum;
                                        state <= POINT;
                                    end
                                endcase
                            end
                        end
                    end
                    ROLLP: begin
                        if (!roll) begin
                            if (!sum_legal) begin
                                err   <= 1'b1;
                                state <= POINT;
                            end else begin
                                if (!rolls_max) rolls <= rolls + 1'b1;
                                if (sum == point)      state <= WIN;
                                else if (sum == 4'd7)  state <= LOSE;
                                else                   state <= POINT;
                            end
                        end
                    end
                    WIN, LOSE: state <= state;
                    default:   state <= FIRST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Purpose: self-checking bench for dice_game_ctrl (directed table, corner sequences, random vs. model).
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_dice_game_ctrl;

    localparam int RW = 2;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          roll;
    logic          new_game;
    logic [3:0]    sum;
    logic          dice_en;
    logic [3:0]    point;
    logic          win;
    logic          lose;
    logic          err;
    logic [RW-1:0] rolls;

    int checks = 0;
    int fails  = 0;

    dice_game_ctrl #(.ROLLS_W(RW)) dut (
        .clk(clk), .reset(reset), .roll(roll), .new_game(new_game), .sum(sum),
        .dice_en(dice_en), .point(point), .win(win), .lose(lose), .err(err), .rolls(rolls)
    );

    always #5 clk = ~clk;

    // Reference model: game described as "point known or not", outcome, rolling flag.
    int m_prev_roll, m_rolling, m_outcome, m_point, m_rolls, m_err; // outcome 0 none, 1 win, 2 lose

    task automatic model_reset();
        m_prev_roll = 0; m_rolling = 0; m_outcome = 0; m_point = 0; m_rolls = 0; m_err = 0;
    endtask

    task automatic model_edge(input int r, input int ng, input int s);
        int pressed;
        pressed = (r != 0) && (m_prev_roll == 0);
        m_prev_roll = r;
        m_err = 0;
        if (ng != 0) begin
            m_rolling = 0; m_outcome = 0; m_point = 0; m_rolls = 0;
        end else if (m_outcome == 0) begin
            if (m_rolling == 0) begin
                if (pressed) m_rolling = 1;
            end else if (r == 0) begin
                m_rolling = 0;
                if (s < 2 || s > 12) begin
                    m_err = 1;
                end else begin
                    m_rolls = (m_rolls + 1 > RMAX) ? RMAX : m_rolls + 1;
                    if (m_point == 0) begin
                        if (s == 7 || s == 11) m_outcome = 1;
                        else if (s == 2 || s == 3 || s == 12) m_outcome = 2;
                        else m_point = s;
                    end else if (s == m_point) m_outcome = 1;
                    else if (s == 7) m_outcome = 2;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int en, input int pt, input int w,
                           input int l, input int e, input int rl);
        chk({tag, ".dice_en"}, int'(dice_en), en);
        chk({tag, ".point"},   int'(point),   pt);
        chk({tag, ".win"},     int'(win),     w);
        chk({tag, ".lose"},    int'(lose),    l);
        chk({tag, ".err"},     int'(err),     e);
        chk({tag, ".rolls"},   int'(rolls),   rl);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_rolling, m_point, int'(m_outcome == 1), int'(m_outcome == 2), m_err, m_rolls);
    endtask

    task automatic step(input logic r, input logic ng, input logic [3:0] s);
        @(negedge clk);
        roll = r; new_game = ng; sum = s;
        @(posedge clk);
        model_edge(int'(r), int'(ng), int'(s));
        #1;
    endtask

    typedef struct {
        logic       r, ng;
        logic [3:0] s;
        int         en, pt, w, l, e, rl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ng, input logic [3:0] s, input int en,
                       input int pt, input int w, input int l, input int e, input int rl);
        vec_t v;
        v.r = r; v.ng = ng; v.s = s; v.en = en; v.pt = pt; v.w = w; v.l = l; v.e = e; v.rl = rl;
        vecs.push_back(v);
    endtask

    initial begin
        //  roll ng sum   en pt w l e rolls
        add(0, 0, 5,     0, 0, 0, 0, 0, 0);  // idle
        add(1, 0, 5,     1, 0, 0, 0, 0, 0);  // press
        add(1, 0, 9,     1, 0, 0, 0, 0, 0);  // hold
        add(0, 0, 7,     0, 0, 1, 0, 0, 1);  // natural 7
        add(1, 0, 4,     0, 0, 1, 0, 0, 1);  // roll ignored in WIN
        add(0, 1, 4,     0, 0, 0, 0, 0, 0);  // new game
        add(1, 0, 3,     1, 0, 0, 0, 0, 0);
        add(0, 0, 3,     0, 0, 0, 1, 0, 1);  // craps 3
        add(1, 1, 3,     0, 0, 0, 0, 0, 0);  // restart with roll held
        add(1, 0, 3,     0, 0, 0, 0, 0, 0);  // held roll is not a press
        add(0, 0, 6,     0, 0, 0, 0, 0, 0);
        add(1, 0, 6,     1, 0, 0, 0, 0, 0);
        add(0, 0, 6,     0, 6, 0, 0, 0, 1);  // point 6
        add(1, 0, 9,     1, 6, 0, 0, 0, 1);
        add(0, 0, 9,     0, 6, 0, 0, 0, 2);  // no decision
        add(1, 0, 6,     1, 6, 0, 0, 0, 2);
        add(0, 0, 6,     0, 6, 1, 0, 0, 3);  // point made
        add(0, 1, 6,     0, 0, 0, 0, 0, 0);
        add(1, 0, 8,     1, 0, 0, 0, 0, 0);
        add(0, 0, 8,     0, 8, 0, 0, 0, 1);  // point 8
        add(1, 0, 7,     1, 8, 0, 0, 0, 1);
        add(0, 0, 7,     0, 8, 0, 1, 0, 2);  // seven-out, point kept
        add(0, 1, 7,     0, 0, 0, 0, 0, 0);
        add(1, 0, 13,    1, 0, 0, 0, 0, 0);
        add(0, 0, 13,    0, 0, 0, 0, 1, 0);  // illegal on first roll
        add(0, 0, 4,     0, 0, 0, 0, 0, 0);  // err is a single cycle
        add(1, 0, 4,     1, 0, 0, 0, 0, 0);
        add(0, 0, 4,     0, 4, 0, 0, 0, 1);
        add(1, 0, 15,    1, 4, 0, 0, 0, 1);
        add(0, 0, 15,    0, 4, 0, 0, 1, 1);  // illegal on point roll
        add(0, 0, 4,     0, 4, 0, 0, 0, 1);
        add(1, 0, 4,     1, 4, 0, 0, 0, 1);
        add(0, 1, 4,     0, 0, 0, 0, 0, 0);  // new_game beats release
        add(1, 0, 5,     1, 0, 0, 0, 0, 0);
        add(0, 0, 5,     0, 5, 0, 0, 0, 1);
        add(1, 0, 9,     1, 5, 0, 0, 0, 1);
        add(0, 0, 9,     0, 5, 0, 0, 0, 2);
        add(1, 0, 10,    1, 5, 0, 0, 0, 2);
        add(0, 0, 10,    0, 5, 0, 0, 0, 3);
        add(1, 0, 8,     1, 5, 0, 0, 0, 3);
        add(0, 0, 8,     0, 5, 0, 0, 0, 3);  // saturated
        add(1, 0, 5,     1, 5, 0, 0, 0, 3);
        add(0, 0, 5,     0, 5, 1, 0, 0, 3);  // scoring still happens
        add(0, 1, 2,     0, 0, 0, 0, 0, 0);
        add(1, 0, 2,     1, 0, 0, 0, 0, 0);
        add(0, 0, 2,     0, 0, 0, 1, 0, 1);  // craps 2
        add(0, 1, 12,    0, 0, 0, 0, 0, 0);
        add(1, 0, 12,    1, 0, 0, 0, 0, 0);
        add(0, 0, 12,    0, 0, 0, 1, 0, 1);  // craps 12
        add(1, 0, 12,    0, 0, 0, 1, 0, 1);  // press in LOSE ignored
        add(0, 1, 0,     0, 0, 0, 0, 0, 0);

        reset = 1'b0; roll = 1'b0; new_game = 1'b0; sum = 4'd0;
        model_reset();
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].ng, vecs[i].s);
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].pt, vecs[i].w,
                    vecs[i].l, vecs[i].e, vecs[i].rl);
        end

        // Asynchronous reset in the middle of a point roll.
        step(1, 0, 6);
        step(0, 0, 6);
        step(1, 0, 9);
        chk("pre_reset.dice_en", int'(dice_en), 1);
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        roll = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, ng;
            logic [3:0] s;
            r  = ($urandom_range(0, 2) != 0) ? roll : ~roll;
            ng = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 12));
            step(r, ng, s);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Craps-style game controller that drives the two-dice sum counter and consumes its output. It gates the counter's `enable` while the player holds the roll button, then samples the 4-bit sum (2..12) when the button is released. It scores the result under first-roll/point rules and holds the win or lose outcome until a new game is requested. It sits between the user inputs (roll, new_game) and the sum counter, and feeds the display/LED logic.

## Interface
- `ROLLS_W`, default 4: width of the completed-roll counter; saturates at 2^ROLLS_W-1.
- `clk`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state and outputs immediately.
- `roll`, in, 1: roll button level, already synchronised and debounced; 1 = held.
- `new_game`, in, 1: level, synchronous; restarts the game.
- `sum`, in, 4: dice sum from the counter; legal range 2..12.
- `dice_en`, out, 1: counter enable; high only while rolling.
- `point`, out, 4: established point value; 0 when no point is set.
- `win`, out, 1: game won; held until restart.
- `lose`, out, 1: game lost; held until restart.
- `err`, out, 1: one-cycle pulse when an out-of-range sum is sampled.
- `rolls`, out, ROLLS_W: number of completed legal rolls this game, saturating.

## Operation
- States:
  - `FIRST`: waiting for the first roll.
  - `ROLL1`: first roll in progress.
  - `POINT`: point established, waiting for the next roll.
  - `ROLLP`: point roll in progress.
  - `WIN`, `LOSE`: game over.
- Internal `roll_q` register holds last cycle's `roll`. A press is `roll & ~roll_q`.
- Transitions out of `FIRST`: a press moves to `ROLL1`.
- Transitions out of `POINT`: a press moves to `ROLLP`.
- Releases: `ROLL1` or `ROLLP` with `roll==0` evaluates `sum` at that edge.
- `ROLL1` evaluation:
  - 7 or 11 -> `WIN`.
  - 2, 3 or 12 -> `LOSE`.
  - 4, 5, 6, 8, 9 or 10 -> `point<=sum`, go to `POINT`.
- `ROLLP` evaluation:
  - `sum==point` -> `WIN`.
  - `sum==7` -> `LOSE`.
  - Any other legal value -> `POINT`, point unchanged.
- Illegal sum (0, 1, 13..15) at evaluation:
  - Pulse `err` for one cycle.
  - Do not score and do not increment `rolls`.
  - Return to `FIRST` (from `ROLL1`) or `POINT` (from `ROLLP`).
- Each legal evaluation increments `rolls`, saturating at max.
- `WIN`/`LOSE` ignore `roll` entirely and keep `dice_en` low.
- `new_game==1` in any state, on the next edge:
  - Go to `FIRST`.
  - Clear `point`, `win`, `lose` and `rolls`.
  - Force `err` to 0.
- `new_game` has priority over every roll event in the same cycle.
- Outputs decoded from registered state (Moore):
  - `dice_en = (state==ROLL1 | state==ROLLP)`.
  - `win = (state==WIN)`.
  - `lose = (state==LOSE)`.
- `point` and `rolls` are registers.

## Timing
- Reset asserted (low): state `FIRST`, `roll_q=0`, `dice_en=0`, `point=0`, `win=0`, `lose=0`, `err=0`, `rolls=0`. Reset mid-roll drops `dice_en` immediately.
- Press latency: `roll` rises before edge N; state enters `ROLL1`/`ROLLP` at edge N; `dice_en` is high from edge N.
- `roll` already high when the block enters `FIRST`/`POINT` (held through a restart) is not a press; a fresh rising edge is required.
- Release latency: `roll` low before edge M while in a ROLL state; `sum` is sampled at edge M.
  - The new state, `point`, `rolls` and `err` are visible after edge M.
  - `dice_en` falls after edge M.
  - The counter still advances at edge M; the pre-edge `sum` value is the one scored.
- Minimum roll: a press at edge N and release at edge N+1 gives one full enabled cycle.
- `err` is high for exactly the cycle following edge M, then clears.
- `rolls` saturates: at max, a further legal roll leaves it unchanged while scoring still happens.

## Test plan
- Reset then first roll sum 7: `reset` low then high, press `roll`, release when `sum==7` → `win=1`, `lose=0`, `point=0`, `rolls=1`, `dice_en=0`. Then `new_game` for one cycle → all outputs 0, state `FIRST`.
- First roll 2/3/12: release with `sum` = 2, 3 and 12 in separate games → `lose=1` after each; `roll` presses while in `LOSE` leave `dice_en=0`.
- Point made: first roll `sum=6` → `point=6`, `rolls=1`. Next roll `sum=9` → still `POINT`, `rolls=2`. Next roll `sum=6` → `win=1`, `rolls=3`.
- Seven-out: first roll `sum=8` → `point=8`. Next roll `sum=7` → `lose=1`, `point` stays 8.
- Illegal sum: force `sum=13` at release in `ROLL1` → `err` high for one cycle, state `FIRST`, `rolls=0`. Repeat in `ROLLP` → state `POINT`, point kept.
- Priority and async reset:
  - `new_game` and release on the same edge → `FIRST`, nothing scored.
  - `reset` low mid-`ROLLP` → `dice_en` low immediately; `point` and `rolls` are 0.
  - With `ROLLS_W=2`, five legal point rolls → `rolls` saturates at 3.
